dino_motion: RTL and testbench



---
 rtl/dino_motion.sv | 156 +++++++++++++++
 tb/tb_dino_motion.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dino_motion.sv
// Timing and motion core for the dinosaur runner: pixel enable, frame tick,
// running-sprite alternation and jump physics. Optional macro: SHORT_HOP_EN.
module dino_motion #(
    parameter int unsigned FRAME_TICKS = 420000,
    parameter int unsigned RUN_FRAMES  = 6,
    parameter int unsigned JUMP_VEL    = 12,
    parameter int unsigned GRAVITY     = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       restart,
    input  logic       button,
    input  logic       halt,
    output logic       pix_en,
    output logic       frame_tick,
    output logic       run_frame,
    output logic [6:0] jump_addr,
    output logic       airborne
);

    localparam int unsigned FW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int unsigned RW = (RUN_FRAMES > 1) ? $clog2(RUN_FRAMES) : 1;

    localparam logic [FW-1:0]      FRM_LAST   = FW'(FRAME_TICKS - 1);
    localparam logic [RW-1:0]      RUN_LAST   = RW'(RUN_FRAMES - 1);
    localparam logic [6:0]         POS_LAUNCH = 7'(JUMP_VEL);
    localparam logic signed [5:0]  VEL_LAUNCH = 6'(JUMP_VEL - GRAVITY);
    localparam logic signed [5:0]  GRAV       = 6'(GRAVITY);

    typedef enum logic {
        GROUND = 1'b0,
        AIR    = 1'b1
    } jump_state_e;

    logic [1:0]        div_q, div_d;
    logic              pix_en_q, pix_en_d;
    logic [FW-1:0]     frm_cnt_q, frm_cnt_d;
    logic              frame_tick_q, frame_tick_d;
    logic [RW-1:0]     run_cnt_q, run_cnt_d;
    logic              run_frame_q, run_frame_d;
    logic              btn_meta_q, btn_s_q;
    jump_state_e       state_q, state_d;
    logic [6:0]        pos_q, pos_d;
    logic signed [5:0] vel_q, vel_d;
    logic signed [5:0] vel_eff;
    logic signed [8:0] sum;
    logic              update;

    // Frame counter advances on the same edge that raises pix_en, so the
    // wrap (and frame_tick) lands on edge 4*FRAME_TICKS.
    always_comb begin
        div_d        = div_q + 2'd1;
        pix_en_d     = (div_q == 2'd3);
        frm_cnt_d    = frm_cnt_q;
        frame_tick_d = 1'b0;
        if (div_q == 2'd3) begin
            if (frm_cnt_q == FRM_LAST) begin
                frm_cnt_d    = '0;
                frame_tick_d = 1'b1;
            end else begin
                frm_cnt_d = frm_cnt_q + FW'(1);
            end
        end
    end

    always_comb begin
        run_cnt_d   = run_cnt_q;
        run_frame_d = run_frame_q;
        if (restart) begin
            run_cnt_d   = '0;
            run_frame_d = 1'b1;
        end else if (frame_tick_q && !halt) begin
            if (run_cnt_q == RUN_LAST) begin
                run_cnt_d   = '0;
                run_frame_d = !run_frame_q;
            end else begin
                run_cnt_d = run_cnt_q + RW'(1);
            end
        end
    end

    always_comb begin
        update  = frame_tick_q && !halt;
        vel_eff = vel_q;
`ifdef SHORT_HOP_EN
        if (!btn_s_q && (vel_q > 6'sd4)) begin
            vel_eff = 6'sd4;
        end
`endif
        sum     = $signed({2'b00, pos_q}) + $signed({{3{vel_eff[5]}}, vel_eff});
        state_d = state_q;
        pos_d   = pos_q;
        vel_d   = vel_q;
        if (restart) begin
            state_d = GROUND;
            pos_d   = '0;
            vel_d   = '0;
        end else if (update) begin
            case (state_q)
                GROUND: begin
                    if (btn_s_q) begin
                        state_d = AIR;
                        pos_d   = POS_LAUNCH;
                        vel_d   = VEL_LAUNCH;
                    end
                end
                AIR: begin
                    if (sum <= 9'sd0) begin
                        state_d = GROUND;
                        pos_d   = '0;
                        vel_d   = '0;
                    end else begin
                        // Velocity keeps decaying while clipped so the jump still comes down.
                        pos_d = (sum > 9'sd127) ? 7'd127 : sum[6:0];
                        vel_d = vel_eff - GRAV;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q        <= '0;
            pix_en_q     <= 1'b0;
            frm_cnt_q    <= '0;
            frame_tick_q <= 1'b0;
            run_cnt_q    <= '0;
            run_frame_q  <= 1'b1;
            btn_meta_q   <= 1'b0;
            btn_s_q      <= 1'b0;
            state_q      <= GROUND;
            pos_q        <= '0;
            vel_q        <= '0;
        end else begin
            div_q        <= div_d;
            pix_en_q     <= pix_en_d;
            frm_cnt_q    <= frm_cnt_d;
            frame_tick_q <= frame_tick_d;
            run_cnt_q    <= run_cnt_d;
            run_frame_q  <= run_frame_d;
            btn_meta_q   <= button;
            btn_s_q      <= btn_meta_q;
            state_q      <= state_d;
            pos_q        <= pos_d;
            vel_q        <= vel_d;
        end
    end

    assign pix_en     = pix_en_q;
    assign frame_tick = frame_tick_q;
    assign run_frame  = run_frame_q;
    assign jump_addr  = pos_q;
    assign airborne   = (state_q == AIR);

endmodule

// File: tb/tb_dino_motion.sv
// Directed bench for dino_motion (FRAME_TICKS=4, RUN_FRAMES=2); expected
// per-frame outputs are queued ahead of each frame and checked as they appear.
module tb_dino_motion;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       restart;
    logic       button;
    logic       halt;
    logic       pix_en;
    logic       frame_tick;
    logic       run_frame;
    logic [6:0] jump_addr;
    logic       airborne;

    int errors = 0;
    int checks = 0;
    int edge_cnt;

    typedef struct {
        logic [6:0] addr;
        logic       airb;
    } exp_t;

    exp_t jq[$];
    logic rq[$];

    int prof_full[24] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78,
                          78, 77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12};
    int prof_short[12] = '{12, 16, 19, 21, 22, 22, 21, 19, 16, 12, 7, 1};

    dino_motion #(
        .FRAME_TICKS(4),
        .RUN_FRAMES (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .restart   (restart),
        .button    (button),
        .halt      (halt),
        .pix_en    (pix_en),
        .frame_tick(frame_tick),
        .run_frame (run_frame),
        .jump_addr (jump_addr),
        .airborne  (airborne)
    );

    always #5 clk = ~clk;

    // Rising edges seen since reset_n last released.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_jump(input int addr, input bit airb);
        exp_t e;
        e.addr = 7'(addr);
        e.airb = airb;
        jq.push_back(e);
    endtask

    // Waits for a frame_tick pulse, then returns on the negedge after the update edge.
    task automatic next_frame();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("frame_tick_seen", 32'(got), 1);
        if (got) check("frame_tick_phase", edge_cnt % 16, 0);
        @(negedge clk);
    endtask

    task automatic check_jump();
        exp_t e;
        e = jq.pop_front();
        check("jump_addr", 32'(jump_addr), 32'(e.addr));
        check("airborne", 32'(airborne), 32'(e.airb));
    endtask

    task automatic check_run();
        logic r;
        r = rq.pop_front();
        check("run_frame", 32'(run_frame), 32'(r));
    endtask

    initial begin
        bit first;
        reset_n = 1'b0;
        restart = 1'b0;
        button  = 1'b0;
        halt    = 1'b0;

        #12;
        check("rst_pix_en", 32'(pix_en), 0);
        check("rst_frame_tick", 32'(frame_tick), 0);
        check("rst_run_frame", 32'(run_frame), 1);
        check("rst_jump_addr", 32'(jump_addr), 0);
        check("rst_airborne", 32'(airborne), 0);

        @(negedge clk);
        reset_n = 1'b1;

        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check("pix_en_phase", 32'(pix_en), (edge_cnt % 4 == 0) ? 1 : 0);
            check("frame_tick_early", 32'(frame_tick), 0);
        end
        check("idle_jump_addr", 32'(jump_addr), 0);
        check("idle_airborne", 32'(airborne), 0);

        // Running sprite, then frozen by halt, then resumed.
        rq.push_back(1'b1); rq.push_back(1'b0); rq.push_back(1'b0);
        rq.push_back(1'b1); rq.push_back(1'b1); rq.push_back(1'b0);
        while (rq.size() != 0) begin next_frame(); check_run(); end
        halt = 1'b1;
        for (int k = 0; k < 5; k++) rq.push_back(1'b0);
        while (rq.size() != 0) begin next_frame(); check_run(); end
        halt = 1'b0;
        rq.push_back(1'b0); rq.push_back(1'b1);
        while (rq.size() != 0) begin next_frame(); check_run(); end

        // Button held for one frame only.
        button = 1'b1;
`ifdef SHORT_HOP_EN
        foreach (prof_short[i]) push_jump(prof_short[i], 1'b1);
`else
        foreach (prof_full[i]) push_jump(prof_full[i], 1'b1);
`endif
        push_jump(0, 1'b0);
        first = 1'b1;
        while (jq.size() != 0) begin
            next_frame();
            if (first) begin
                button = 1'b0;
                first  = 1'b0;
            end
            check_jump();
        end

        // Button held through landing: relaunch on the next frame.
        button = 1'b1;
        foreach (prof_full[i]) push_jump(prof_full[i], 1'b1);
        push_jump(0, 1'b0);
        push_jump(12, 1'b1); push_jump(23, 1'b1); push_jump(33, 1'b1); push_jump(42, 1'b1);
        while (jq.size() != 0) begin next_frame(); check_jump(); end

        // Halt at 42 for three frames.
        halt = 1'b1;
        push_jump(42, 1'b1); push_jump(42, 1'b1); push_jump(42, 1'b1);
        while (jq.size() != 0) begin next_frame(); check_jump(); end
        halt = 1'b0;
        push_jump(50, 1'b1); push_jump(57, 1'b1);
        while (jq.size() != 0) begin next_frame(); check_jump(); end

        // Restart pulse at 57.
        button  = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_jump_addr", 32'(jump_addr), 0);
        check("restart_airborne", 32'(airborne), 0);
        check("restart_run_frame", 32'(run_frame), 1);
        for (int k = 0; k < 8; k++) begin
            check("restart_pix_en_phase", 32'(pix_en), (edge_cnt % 4 == 0) ? 1 : 0);
            @(negedge clk);
        end

        // Restart and halt together: restart must win.
        button = 1'b1;
        push_jump(12, 1'b1); push_jump(23, 1'b1);
        while (jq.size() != 0) begin next_frame(); check_jump(); end
        halt    = 1'b1;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        halt    = 1'b0;
        check("rst_halt_jump_addr", 32'(jump_addr), 0);
        check("rst_halt_airborne", 32'(airborne), 0);
        push_jump(12, 1'b1); push_jump(23, 1'b1);
        while (jq.size() != 0) begin next_frame(); check_jump(); end

        // Asynchronous reset during a jump.
        reset_n = 1'b0;
        #1;
        check("async_rst_jump_addr", 32'(jump_addr), 0);
        check("async_rst_airborne", 32'(airborne), 0);
        check("async_rst_run_frame", 32'(run_frame), 1);
        check("async_rst_pix_en", 32'(pix_en), 0);
        button = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        push_jump(0, 1'b0);
        while (jq.size() != 0) begin next_frame(); check_jump(); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
